// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing one regfile write port between N_REQ requesters,
// with an init sequencer that sweeps every register to INIT_VAL.
module regfile_wport_arbiter #(
  parameter int               WIDTH       = 32,
  parameter int               N_REG       = 32,
  parameter int               N_REQ       = 4,
  parameter bit               INIT_ON_RST = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VAL    = '0,
  localparam int              AW          = $clog2(N_REG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_start,
  output logic                   init_busy,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic                   rf_wen,
  output logic [AW-1:0]          rf_waddr,
  output logic [WIDTH-1:0]       rf_wdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {S_INIT, S_ARB} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  cnt;
  logic [PW-1:0]  rr_ptr, rr_nxt;
  logic [N_REQ-1:0] gnt;
  logic           gnt_any;
  logic [AW-1:0]  g_addr;
  logic [WIDTH-1:0] g_data;
  logic           xfer, in_range, cnt_last;
  int             idx;

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    g_addr  = '0;
    g_data  = '0;
    rr_nxt  = rr_ptr;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_any  = 1'b1;
        g_addr   = req_addr[idx*AW +: AW];
        g_data   = req_data[idx*WIDTH +: WIDTH];
        rr_nxt   = PW'((idx + 1) % N_REQ);
      end
    end
  end

  assign cnt_last = (cnt == AW'(N_REG - 1));
  assign in_range = (int'(g_addr) < N_REG);
  assign xfer     = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (rst) state <= INIT_ON_RST ? S_INIT : S_ARB;
    else     state <= state_nxt;
  end

  // A pending init_start blocks every grant in the same cycle.
  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    req_ready = '0;
    case (state)
      S_INIT: begin
        init_busy = ~rst;
        if (cnt_last) state_nxt = S_ARB;
      end
      S_ARB: begin
        if (init_start)  state_nxt = S_INIT;
        else if (!rst)   req_ready = gnt;
      end
      default: state_nxt = S_ARB;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      rf_wen <= 1'b0;
      if (state == S_INIT) begin
        rf_wen   <= 1'b1;
        rf_waddr <= cnt;
        rf_wdata <= INIT_VAL;
        cnt      <= cnt_last ? '0 : cnt + AW'(1);
      end else if (xfer) begin
        rr_ptr <= rr_nxt;
        // Out-of-range addresses complete the handshake but are dropped.
        if (in_range) begin
          rf_wen   <= 1'b1;
          rf_waddr <= g_addr;
          rf_wdata <= g_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench: instance A (N_REG=8, init on reset) and instance B
// (N_REG=6, no init on reset, out-of-range address handling).
module tb_regfile_wport_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A
  logic        rst_a, init_start_a, init_busy_a, rf_wen_a;
  logic [3:0]  req_valid_a, req_ready_a;
  logic [11:0] req_addr_a;
  logic [127:0] req_data_a;
  logic [2:0]  rf_waddr_a;
  logic [31:0] rf_wdata_a;

  // Instance B
  logic        rst_b, init_start_b, init_busy_b, rf_wen_b;
  logic [3:0]  req_valid_b, req_ready_b;
  logic [11:0] req_addr_b;
  logic [127:0] req_data_b;
  logic [2:0]  rf_waddr_b;
  logic [31:0] rf_wdata_b;

  regfile_wport_arbiter #(
    .WIDTH(32), .N_REG(8), .N_REQ(4), .INIT_ON_RST(1'b1), .INIT_VAL(32'h0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .init_start(init_start_a), .init_busy(init_busy_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_addr(req_addr_a),
    .req_data(req_data_a), .rf_wen(rf_wen_a), .rf_waddr(rf_waddr_a),
    .rf_wdata(rf_wdata_a)
  );

  regfile_wport_arbiter #(
    .WIDTH(32), .N_REG(6), .N_REQ(4), .INIT_ON_RST(1'b0), .INIT_VAL(32'h5A)
  ) dut_b (
    .clk(clk), .rst(rst_b), .init_start(init_start_b), .init_busy(init_busy_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
    .req_data(req_data_b), .rf_wen(rf_wen_b), .rf_waddr(rf_waddr_b),
    .rf_wdata(rf_wdata_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] data_a(input int i);
    return 32'hD0D0_0000 + 32'(i);
  endfunction

  initial begin
    rst_a = 1'b1; init_start_a = 1'b0; req_valid_a = 4'b1111;
    rst_b = 1'b1; init_start_b = 1'b0; req_valid_b = 4'b0000;
    req_addr_b = '0; req_data_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr_a[i*3 +: 3]   = 3'(7 - i);
      req_data_a[i*32 +: 32] = data_a(i);
    end

    // Reset values
    tick(); tick();
    check("rst_busy",  64'(init_busy_a), 64'(0));
    check("rst_wen",   64'(rf_wen_a),    64'(0));
    check("rst_waddr", 64'(rf_waddr_a),  64'(0));
    check("rst_wdata", 64'(rf_wdata_a),  64'(0));
    check("rst_ready", 64'(req_ready_a), 64'(0));

    // Init sweep after reset
    rst_a = 1'b0;
    settle();
    for (int k = 0; k < 8; k++) begin
      check("init_busy",  64'(init_busy_a), 64'(1));
      check("init_ready", 64'(req_ready_a), 64'(0));
      tick();
      check("init_wen",   64'(rf_wen_a),   64'(1));
      check("init_waddr", 64'(rf_waddr_a), 64'(k));
      check("init_wdata", 64'(rf_wdata_a), 64'(0));
    end
    check("init_done", 64'(init_busy_a), 64'(0));

    // Full rotation under continuous load
    for (int j = 0; j < 6; j++) begin
      settle();
      check("rot_ready", 64'(req_ready_a), 64'(4'b0001 << (j % 4)));
      tick();
      check("rot_wen",   64'(rf_wen_a),   64'(1));
      check("rot_waddr", 64'(rf_waddr_a), 64'(7 - (j % 4)));
      check("rot_wdata", 64'(rf_wdata_a), 64'(data_a(j % 4)));
    end

    // Grant req3 -> rr_ptr wraps to 0, then lone req2, then rr_ptr=3
    req_valid_a = 4'b1000; settle();
    check("g3_ready", 64'(req_ready_a), 64'(4'b1000));
    tick();
    check("g3_waddr", 64'(rf_waddr_a), 64'(4));
    req_valid_a = 4'b0100; settle();
    check("g2_ready", 64'(req_ready_a), 64'(4'b0100));
    tick();
    check("g2_waddr", 64'(rf_waddr_a), 64'(5));
    req_valid_a = 4'b1111; settle();
    check("ptr3_ready", 64'(req_ready_a), 64'(4'b1000));
    req_valid_a = 4'b0000; settle();
    check("idle_ready", 64'(req_ready_a), 64'(0));
    tick();
    check("idle_wen",   64'(rf_wen_a),   64'(0));
    check("idle_waddr", 64'(rf_waddr_a), 64'(5));
    check("idle_wdata", 64'(rf_wdata_a), 64'(data_a(2)));

    // init_start beats req1; init_start during INIT is ignored
    req_valid_a = 4'b0010; init_start_a = 1'b1; settle();
    check("istart_ready", 64'(req_ready_a), 64'(0));
    tick();
    init_start_a = 1'b0;
    check("istart_wen", 64'(rf_wen_a), 64'(0));
    for (int k = 0; k < 8; k++) begin
      init_start_a = (k == 2);
      settle();
      check("sw_busy",  64'(init_busy_a), 64'(1));
      check("sw_ready", 64'(req_ready_a), 64'(0));
      tick();
      check("sw_waddr", 64'(rf_waddr_a), 64'(k));
    end
    init_start_a = 1'b0; settle();
    check("sw_done",   64'(init_busy_a), 64'(0));
    check("post_ready", 64'(req_ready_a), 64'(4'b0010));
    tick();
    check("post_wen",   64'(rf_wen_a),   64'(1));
    check("post_waddr", 64'(rf_waddr_a), 64'(6));
    check("post_wdata", 64'(rf_wdata_a), 64'(data_a(1)));
    req_valid_a = 4'b0000;

    // Reset in the middle of a sweep
    init_start_a = 1'b1; settle();
    tick();
    init_start_a = 1'b0;
    tick(); tick(); tick();
    check("mid_waddr", 64'(rf_waddr_a), 64'(2));
    rst_a = 1'b1; settle();
    check("mid_rst_busy", 64'(init_busy_a), 64'(0));
    tick();
    check("mid_rst_wen",   64'(rf_wen_a),   64'(0));
    check("mid_rst_waddr", 64'(rf_waddr_a), 64'(0));
    rst_a = 1'b0; settle();
    check("restart_busy", 64'(init_busy_a), 64'(1));
    tick();
    check("restart_wen",   64'(rf_wen_a),   64'(1));
    check("restart_waddr", 64'(rf_waddr_a), 64'(0));
    for (int k = 0; k < 7; k++) tick();
    check("restart_last", 64'(rf_waddr_a), 64'(7));
    check("restart_done", 64'(init_busy_a), 64'(0));

    // Instance B: no init on reset, out-of-range address dropped
    rst_b = 1'b0; settle();
    check("b_busy", 64'(init_busy_b), 64'(0));
    check("b_wen",  64'(rf_wen_b),    64'(0));
    req_addr_b[0*3 +: 3]   = 3'd7;
    req_data_b[0*32 +: 32] = 32'h1111_1111;
    req_addr_b[1*3 +: 3]   = 3'd5;
    req_data_b[1*32 +: 32] = 32'h0000_BEEF;
    req_valid_b = 4'b0001; settle();
    check("oor_ready", 64'(req_ready_b), 64'(4'b0001));
    tick();
    check("oor_wen",   64'(rf_wen_b),   64'(0));
    check("oor_waddr", 64'(rf_waddr_b), 64'(0));
    req_valid_b = 4'b0011; settle();
    check("oor_ptr_ready", 64'(req_ready_b), 64'(4'b0010));
    tick();
    check("b_wen1",   64'(rf_wen_b),   64'(1));
    check("b_waddr1", 64'(rf_waddr_b), 64'(5));
    check("b_wdata1", 64'(rf_wdata_b), 64'(32'h0000_BEEF));
    req_valid_b = 4'b0000;
    init_start_b = 1'b1; settle();
    tick();
    init_start_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("b_sw_busy", 64'(init_busy_b), 64'(1));
      tick();
      check("b_sw_waddr", 64'(rf_waddr_b), 64'(k));
      check("b_sw_wdata", 64'(rf_wdata_b), 64'(32'h5A));
    end
    check("b_sw_done", 64'(init_busy_b), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
